// File: rtl/cocochip_pkg.sv
// Shared definitions for the cocochip ADC front end: sequencer states,
// MUX channel codes and a small unsigned max helper.
package cocochip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONVERT,
    WAIT_EOC,
    EMIT,
    DONE,
    ERROR
  } seq_state_e;

  localparam logic [1:0] CH_HIGH = 2'b00;
  localparam logic [1:0] CH_MID  = 2'b01;
  localparam logic [1:0] CH_LOW  = 2'b10;

  // Ties keep the held value.
  function automatic logic [7:0] max_u8(input logic [7:0] held, input logic [7:0] cand);
    return (cand > held) ? cand : held;
  endfunction

endpackage

// File: rtl/cocochip_adc_sequencer_if.sv
// ADC/MUX control and per-channel peak stream of the ADC sequencer.
interface cocochip_adc_sequencer_if;
  logic       adc_eoc;
  logic [7:0] adc_dout;
  logic       adc_convst;
  logic [1:0] adc_channel_sel;
  logic [7:0] peak_data;
  logic       peak_valid;
  logic [1:0] peak_channel;

  modport master (
    input  adc_eoc, adc_dout,
    output adc_convst, adc_channel_sel, peak_data, peak_valid, peak_channel
  );

  modport slave (
    output adc_eoc, adc_dout,
    input  adc_convst, adc_channel_sel, peak_data, peak_valid, peak_channel
  );
endinterface

// File: rtl/cocochip_sync2.sv
// Generic 2-flop synchroniser, asynchronous active-low reset.
module cocochip_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [1:0][WIDTH-1:0] sync_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_pipe <= '0;
    else          sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];
endmodule

// File: rtl/cocochip_adc_sequencer.sv
// Walks the analog MUX through high/mid/low, settles, converts SAMPLES_PER_CH
// times per channel and emits one peak per channel; aborts to ERROR on EOC timeout.
module cocochip_adc_sequencer
  import cocochip_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 500,
  parameter int SAMPLES_PER_CH = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  cocochip_adc_sequencer_if.master        adc,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int NW = $clog2(SAMPLES_PER_CH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [NW-1:0] SAMPLES_N   = NW'(SAMPLES_PER_CH);
  // The convst cycle is the first cycle of the timeout window, so WAIT_EOC
  // gives up on its (TIMEOUT_CYCLES-1)th cycle.
  localparam int            TMO_LAST_I  = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0;
  localparam logic [TW-1:0] TMO_LAST    = TW'(TMO_LAST_I);

  seq_state_e    state, state_nxt;
  logic [SW-1:0] settle_cnt;
  logic [NW-1:0] samp_cnt, samp_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    ch;
  logic [7:0]    peak;
  logic          eoc_s, eoc_q, eoc_rise;

  cocochip_sync2 #(.WIDTH(1)) u_eoc_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (adc.adc_eoc),
    .q       (eoc_s)
  );

  // A level already high at CONVERT never shows up as a rise here.
  assign eoc_rise = eoc_s & ~eoc_q;
  assign samp_nxt = samp_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt           = state;
    adc.adc_convst      = 1'b0;
    adc.adc_channel_sel = ch;
    adc.peak_data       = peak;
    adc.peak_valid      = 1'b0;
    adc.peak_channel    = ch;
    busy                = 1'b0;
    done                = 1'b0;
    error               = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = SETTLE;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_nxt = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_LAST) state_nxt = CONVERT;
      end
      CONVERT: begin
        busy           = 1'b1;
        adc.adc_convst = 1'b1;
        state_nxt      = WAIT_EOC;
      end
      WAIT_EOC: begin
        busy = 1'b1;
        if (eoc_rise)                state_nxt = (samp_nxt == SAMPLES_N) ? EMIT : CONVERT;
        else if (tmo_cnt == TMO_LAST) state_nxt = ERROR;
      end
      EMIT: begin
        busy           = 1'b1;
        adc.peak_valid = 1'b1;
        state_nxt      = (ch == CH_LOW) ? DONE : SETTLE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
      samp_cnt   <= '0;
      tmo_cnt    <= '0;
      ch         <= CH_HIGH;
      peak       <= '0;
      eoc_q      <= 1'b0;
    end else begin
      eoc_q <= eoc_s;
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            ch         <= CH_HIGH;
            settle_cnt <= '0;
            samp_cnt   <= '0;
          end
        end
        SETTLE:  settle_cnt <= settle_cnt + 1'b1;
        CONVERT: tmo_cnt    <= '0;
        WAIT_EOC: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (eoc_rise) begin
            peak     <= (samp_cnt == '0) ? adc.adc_dout : max_u8(peak, adc.adc_dout);
            samp_cnt <= samp_nxt;
          end
        end
        EMIT: begin
          if (ch != CH_LOW) begin
            ch         <= ch + 1'b1;
            samp_cnt   <= '0;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cocochip_adc_sequencer.sv
// Directed bench for cocochip_adc_sequencer: ADC model with an 8-cycle conversion,
// a run-level scoreboard checked every cycle, and hand-computed expectations.
module tb_cocochip_adc_sequencer;
  localparam int SETTLE = 4;
  localparam int NSAMP  = 4;
  localparam int TMO    = 20;
  localparam int CONV   = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic busy, done, error;

  cocochip_adc_sequencer_if bus ();

  cocochip_adc_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .SAMPLES_PER_CH (NSAMP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .adc     (bus),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check_eq(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // ---------------- ADC model ----------------
  byte unsigned tbl[12];
  int  hang_idx = -1;
  bit  stale    = 1'b0;
  int  run_id   = 0;
  int  seen_run = 0;
  int  conv_idx = 0;
  int  age      = -1;
  bit  hang     = 1'b0;
  logic [7:0] cur = 8'd0;

  always @(negedge clk) begin
    if (run_id != seen_run) begin
      seen_run = run_id;
      conv_idx = 0;
    end
    if (!reset_n) begin
      age          = -1;
      bus.adc_eoc  = stale;
      bus.adc_dout = stale ? 8'd200 : 8'd0;
    end else if (bus.adc_convst) begin
      cur  = tbl[conv_idx % 12];
      hang = (conv_idx == hang_idx);
      if (!(stale && conv_idx == 0)) bus.adc_eoc = 1'b0;
      conv_idx++;
      age = 0;
    end else if (age >= 0) begin
      age++;
      if (age == 4) bus.adc_eoc = 1'b0;
      if (age == CONV && !hang) begin
        bus.adc_dout = cur;
        bus.adc_eoc  = 1'b1;
        age          = -1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int exp_idx = 0, run_cv = 0, since_chg = 0, since_cv = 0;
  int done_cnt = 0, err_cnt = 0;
  bit armed = 1'b0, prev_busy = 1'b0, prev_err = 1'b0, prev_pv = 1'b0;
  logic [1:0] prev_sel = 2'b00;
  int rec_data[$];
  int rec_ch[$];

  function automatic int exp_peak(input int c);
    int m = 0;
    for (int i = 0; i < NSAMP; i++)
      if (int'(tbl[c*NSAMP + i]) > m) m = int'(tbl[c*NSAMP + i]);
    return m;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_idx = 0; run_cv = 0; armed = 1'b0;
      prev_busy = 1'b0; prev_err = 1'b0; prev_pv = 1'b0; prev_sel = 2'b00;
    end else begin
      check_eq("sel_never_11", int'(bus.adc_channel_sel == 2'b11), 0);
      check_eq("busy_excl", int'(busy && (done || error)), 0);
      if ((busy && !prev_busy) || (bus.adc_channel_sel != prev_sel)) begin
        since_chg = 0;
        armed     = 1'b1;
      end else since_chg++;
      since_cv++;
      if (bus.adc_convst) begin
        run_cv++;
        since_cv = 0;
        if (armed) begin
          check_eq("settle_gap", since_chg, SETTLE);
          armed = 1'b0;
        end
      end
      if (bus.peak_valid) begin
        check_eq("peak_channel", int'(bus.peak_channel), exp_idx);
        check_eq("peak_data", int'(bus.peak_data), (exp_idx < 3) ? exp_peak(exp_idx) : -1);
        rec_data.push_back(int'(bus.peak_data));
        rec_ch.push_back(int'(bus.peak_channel));
        exp_idx++;
      end
      if (done) begin
        check_eq("done_after_3_peaks", exp_idx, 3);
        check_eq("convst_per_run", run_cv, 3*NSAMP);
        check_eq("done_follows_peak", int'(prev_pv), 1);
        exp_idx = 0; run_cv = 0;
        done_cnt++;
      end
      if (error && !prev_err) begin
        check_eq("timeout_gap", since_cv, TMO);
        exp_idx = 0; run_cv = 0;
        err_cnt++;
      end
      prev_busy = busy;
      prev_err  = error;
      prev_pv   = bus.peak_valid;
      prev_sel  = bus.adc_channel_sel;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick(1); n++; end
    check_eq(nm, int'(done_cnt >= target), 1);
  endtask

  task automatic load_tbl1();
    tbl = '{8'd10, 8'd50, 8'd30, 8'd20, 8'd5, 8'd5, 8'd5, 8'd5, 8'd255, 8'd0, 8'd1, 8'd2};
  endtask

  initial begin
    int d0, e0, p0, n, cv;
    int exp1[3];
    exp1 = '{50, 5, 255};
    start   = 1'b0;
    reset_n = 1'b0;
    load_tbl1();
    tick(3);
    check_eq("rst_convst", int'(bus.adc_convst), 0);
    check_eq("rst_sel", int'(bus.adc_channel_sel), 0);
    check_eq("rst_peak_data", int'(bus.peak_data), 0);
    check_eq("rst_peak_valid", int'(bus.peak_valid), 0);
    check_eq("rst_busy_done_err", int'({busy, done, error}), 0);
    reset_n = 1'b1;
    tick(3);

    // 1: normal run
    p0 = rec_data.size(); d0 = done_cnt; run_id++;
    pulse_start();
    check_eq("t1_busy_after_start", int'(busy), 1);
    wait_done(d0 + 1, 400, "t1_done_seen");
    check_eq("t1_busy_at_done", int'(busy), 0);
    check_eq("t1_npeaks", rec_data.size() - p0, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("t1_peak_lit", rec_data[p0+i], exp1[i]);
      check_eq("t1_chan_lit", rec_ch[p0+i], i);
    end
    tick(1);
    check_eq("t1_done_one_cycle", int'(done), 0);
    check_eq("t1_busy_after_done", int'(busy), 0);
    tick(3);

    // 3: timeout on mid sample 2
    p0 = rec_data.size(); e0 = err_cnt; hang_idx = 5; run_id++;
    pulse_start();
    n = 0;
    while (err_cnt <= e0 && n < 400) begin tick(1); n++; end
    check_eq("t3_error_seen", int'(err_cnt > e0), 1);
    check_eq("t3_error_busy", int'({error, busy}), 2);
    check_eq("t3_npeaks", rec_data.size() - p0, 1);
    check_eq("t3_peak0_lit", rec_data[p0], 50);
    tick(5);
    check_eq("t3_error_sticky", int'(error), 1);
    hang_idx = -1; run_id++; d0 = done_cnt;
    pulse_start();
    check_eq("t3_error_cleared", int'({error, busy}), 1);
    wait_done(d0 + 1, 400, "t3_rerun_done");
    check_eq("t3_rerun_peaks", rec_data.size() - p0, 4);
    tick(3);

    // 4: stale EOC high from reset
    stale = 1'b1;
    tbl = '{8'd77, 8'd10, 8'd20, 8'd30, 8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd8, 8'd7, 8'd6};
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(4);
    p0 = rec_data.size(); d0 = done_cnt; run_id++;
    pulse_start();
    wait_done(d0 + 1, 400, "t4_done_seen");
    check_eq("t4_stale_peak_lit", rec_data[p0], 77);
    stale = 1'b0;
    tick(3);

    // 5: reset during WAIT_EOC of mid channel
    load_tbl1();
    p0 = rec_data.size(); d0 = done_cnt; run_id++;
    pulse_start();
    n = 0;
    while (rec_data.size() - p0 < 1 && n < 400) begin tick(1); n++; end
    check_eq("t5_first_peak", rec_data.size() - p0, 1);
    n = 0; cv = 0;
    while (cv < 2 && n < 100) begin tick(1); n++; if (bus.adc_convst) cv++; end
    tick(3);
    check_eq("t5_busy_before_rst", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t5_async_outs", int'({bus.adc_convst, bus.adc_channel_sel, bus.peak_data,
                                    bus.peak_valid, bus.peak_channel, busy, done, error}), 0);
    tick(3);
    reset_n = 1'b1;
    p0 = rec_data.size();
    tick(10);
    check_eq("t5_no_done", done_cnt, d0);
    check_eq("t5_no_peak", rec_data.size(), p0);
    run_id++;
    pulse_start();
    wait_done(d0 + 1, 400, "t5_clean_run");
    check_eq("t5_clean_peak0_lit", rec_data[p0], 50);
    check_eq("t5_clean_npeaks", rec_data.size() - p0, 3);
    tick(3);

    // 6: start held high, back-to-back runs
    p0 = rec_data.size(); d0 = done_cnt; run_id++;
    start = 1'b1;
    wait_done(d0 + 2, 700, "t6_two_runs");
    start = 1'b0;
    check_eq("t6_done_count", done_cnt - d0, 2);
    check_eq("t6_npeaks", rec_data.size() - p0, 6);
    tick(20);
    check_eq("t6_idle_after", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
